// File: rtl/clk_duty_meter_pkg.sv
// Shared definitions for the clock-divider family: default counter width and
// the duty-meter FSM state encoding.
package clk_duty_meter_pkg;

  // Default width of the half-cycle counters and result ports.
  localparam int unsigned DEFAULT_W = 6;

  // SYNC: waiting for the first SIG rise, nothing counted.
  // MEAS: inside a period window, accumulating counts.
  typedef enum logic {
    SYNC = 1'b0,
    MEAS = 1'b1
  } meter_state_e;

endpackage

// File: rtl/clk_half_sampler.sv
// Captures SIG on the falling edge of CLK so the posedge logic can see the
// half-cycle sample that precedes each rising edge.
module clk_half_sampler (
  input  logic CLK,
  input  logic CLRn,
  input  logic i_sig,
  output logic o_sample
);

  logic r_sample;

  // Negedge capture with asynchronous clear.
  always_ff @(negedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      r_sample <= 1'b0;
    end else begin
      r_sample <= i_sig;
    end
  end

  assign o_sample = r_sample;

endmodule

// File: rtl/clk_duty_meter.sv
// Measures period and high time of SIG in CLK half-cycles. Each posedge
// processes two samples in order: the negedge sample (h0) then the posedge
// sample (h1). A period window runs from a rise sample up to, but excluding,
// the next rise sample.
module clk_duty_meter
  import clk_duty_meter_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         CLK,
  input  logic         CLRn,
  input  logic         SIG,
  input  logic         ACK,
  output logic         VALID,
  output logic [W-1:0] PERIOD_H,
  output logic [W-1:0] HIGH_H,
  output logic         OVF,
  output logic         MISS
);

  localparam logic [W-1:0] CntMax  = '1;
  localparam logic [W-1:0] CntZero = '0;
  localparam logic [W-1:0] CntOne  = {{(W-1){1'b0}}, 1'b1};

  logic         w_sn;
  meter_state_e r_state, w_state_d;
  logic         r_prev;
  logic [W-1:0] r_cnt_p, r_cnt_h, w_cnt_p_d, w_cnt_h_d;
  logic         w_pub, w_ovf_evt;
  logic [W-1:0] w_pub_p, w_pub_h;

  logic         r_valid, w_valid_d;
  logic [W-1:0] r_period, w_period_d;
  logic [W-1:0] r_high, w_high_d;
  logic         r_ovf, w_ovf_d;
  logic         r_miss, w_miss_d;
  logic         w_accept;

  clk_half_sampler u_sampler (
    .CLK      (CLK),
    .CLRn     (CLRn),
    .i_sig    (SIG),
    .o_sample (w_sn)
  );

  // Walk h0 then h1 through the window rules; at most one rise per step.
  always_comb begin : step_logic
    meter_state_e w_st;
    logic         w_last;
    logic         w_smp;
    logic         w_rise;
    logic [W-1:0] w_p;
    logic [W-1:0] w_h;
    w_st      = r_state;
    w_last    = r_prev;
    w_p       = r_cnt_p;
    w_h       = r_cnt_h;
    w_smp     = 1'b0;
    w_rise    = 1'b0;
    w_pub     = 1'b0;
    w_pub_p   = CntZero;
    w_pub_h   = CntZero;
    w_ovf_evt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_smp  = (i == 0) ? w_sn : SIG;
      w_rise = w_smp & ~w_last;
      case (w_st)
        SYNC: begin
          if (w_rise) begin
            w_st = MEAS;
            w_p  = CntOne;
            w_h  = CntOne;
          end
        end
        MEAS: begin
          if (w_rise) begin
            // Window closes before this sample; it opens the next one.
            w_pub   = 1'b1;
            w_pub_p = w_p;
            w_pub_h = w_h;
            w_p     = CntOne;
            w_h     = CntOne;
          end else if (w_p == CntMax) begin
            // One more sample would not fit: drop the window and resync.
            w_ovf_evt = 1'b1;
            w_st      = SYNC;
            w_p       = CntZero;
            w_h       = CntZero;
          end else begin
            w_p = w_p + CntOne;
            w_h = w_h + {{(W-1){1'b0}}, w_smp};
          end
        end
        default: w_st = SYNC;
      endcase
      w_last = w_smp;
    end
    w_state_d = w_st;
    w_cnt_p_d = w_p;
    w_cnt_h_d = w_h;
  end

  // Measurement state, previous sample and running counts.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      r_state <= SYNC;
      r_prev  <= 1'b0;
      r_cnt_p <= CntZero;
      r_cnt_h <= CntZero;
    end else begin
      r_state <= w_state_d;
      r_prev  <= SIG;
      r_cnt_p <= w_cnt_p_d;
      r_cnt_h <= w_cnt_h_d;
    end
  end

  // Result handshake: a publish into a pending, unaccepted result is dropped.
  always_comb begin : result_next
    w_valid_d  = r_valid;
    w_period_d = r_period;
    w_high_d   = r_high;
    w_ovf_d    = r_ovf;
    w_miss_d   = r_miss;
    w_accept   = r_valid & ACK;
    if (w_accept) begin
      w_miss_d = 1'b0;
    end
    if (w_pub) begin
      w_ovf_d = 1'b0;
      if (!r_valid || ACK) begin
        w_valid_d  = 1'b1;
        w_period_d = w_pub_p;
        w_high_d   = w_pub_h;
      end else begin
        w_miss_d = 1'b1;
      end
    end else begin
      if (w_accept) begin
        w_valid_d = 1'b0;
      end
      if (w_ovf_evt) begin
        w_ovf_d = 1'b1;
      end
    end
  end

  // Result and status registers.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      r_valid  <= 1'b0;
      r_period <= CntZero;
      r_high   <= CntZero;
      r_ovf    <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_valid  <= w_valid_d;
      r_period <= w_period_d;
      r_high   <= w_high_d;
      r_ovf    <= w_ovf_d;
      r_miss   <= w_miss_d;
    end
  end

  assign VALID    = r_valid;
  assign PERIOD_H = r_period;
  assign HIGH_H   = r_high;
  assign OVF      = r_ovf;
  assign MISS     = r_miss;

endmodule

// File: tb/tb_clk_duty_meter.sv
// Bench for clk_duty_meter: directed divider scenarios plus randomized SIG,
// ACK and reset, checked every cycle against a window-based model.
module tb_clk_duty_meter;

  localparam int unsigned W = 6;
  localparam int MaxCnt = (1 << W) - 1;

  logic         CLK  = 1'b0;
  logic         CLRn = 1'b0;
  logic         SIG  = 1'b0;
  logic         ACK  = 1'b0;
  logic         VALID;
  logic [W-1:0] PERIOD_H;
  logic [W-1:0] HIGH_H;
  logic         OVF;
  logic         MISS;

  int checks;
  int failures;
  int cyc;

  clk_duty_meter #(.W(W)) dut (
    .CLK      (CLK),
    .CLRn     (CLRn),
    .SIG      (SIG),
    .ACK      (ACK),
    .VALID    (VALID),
    .PERIOD_H (PERIOD_H),
    .HIGH_H   (HIGH_H),
    .OVF      (OVF),
    .MISS     (MISS)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The sample stream is a list of half-cycle values; the current window is
  // kept as a queue of its samples.
  logic m_sn;
  bit   m_last, m_synced;
  bit   m_win[$];
  bit   m_valid, m_ovf, m_miss;
  int   m_p, m_h;
  bit   t_pub, t_ovf;
  int   t_pp, t_ph;

  task automatic model_reset();
    m_last = 1'b0; m_synced = 1'b0; m_win.delete();
    m_valid = 1'b0; m_ovf = 1'b0; m_miss = 1'b0; m_p = 0; m_h = 0;
  endtask

  task automatic model_sample(input bit s);
    bit rise;
    int ones;
    rise = s && !m_last;
    if (!m_synced) begin
      if (rise) begin
        m_synced = 1'b1;
        m_win.delete();
        m_win.push_back(s);
      end
    end else if (rise) begin
      ones = 0;
      foreach (m_win[k]) ones += int'(m_win[k]);
      t_pub = 1'b1; t_pp = m_win.size(); t_ph = ones;
      m_win.delete();
      m_win.push_back(s);
    end else begin
      m_win.push_back(s);
      if (m_win.size() > MaxCnt) begin
        t_ovf = 1'b1; m_synced = 1'b0; m_win.delete();
      end
    end
    m_last = s;
  endtask

  task automatic model_step(input bit h0, input bit h1, input bit ack);
    bit acc;
    acc = m_valid && ack;
    t_pub = 1'b0; t_ovf = 1'b0;
    model_sample(h0);
    model_sample(h1);
    if (t_pub) begin
      m_ovf = 1'b0;
      if (!m_valid || ack) begin
        m_valid = 1'b1; m_p = t_pp; m_h = t_ph;
      end else begin
        m_miss = 1'b1;
      end
    end else begin
      if (acc) m_valid = 1'b0;
      if (t_ovf) m_ovf = 1'b1;
    end
    if (acc) m_miss = 1'b0;
  endtask

  initial forever begin
    @(negedge CLK or negedge CLRn);
    m_sn = CLRn ? SIG : 1'b0;
  end

  initial forever begin
    @(posedge CLK or negedge CLRn);
    if (!CLRn) begin
      model_reset();
    end else begin
      cyc++;
      model_step(m_sn, SIG, ACK);
    end
  end

  // Compare DUT against model away from the active edge.
  initial forever begin
    @(negedge CLK);
    if (CLRn === 1'b1) begin
      chk("cmp_valid",  int'(VALID),    int'(m_valid));
      chk("cmp_period", int'(PERIOD_H), m_p);
      chk("cmp_high",   int'(HIGH_H),   m_h);
      chk("cmp_ovf",    int'(OVF),      int'(m_ovf));
      chk("cmp_miss",   int'(MISS),     int'(m_miss));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic halves(input logic v, input int n);
    repeat (n) begin
      @(CLK);
      #1 SIG = v;
    end
  endtask

  task automatic div7(input int periods);
    repeat (periods) begin
      halves(1'b1, 7);
      halves(1'b0, 7);
    end
  endtask

  task automatic div4(input int periods);
    repeat (periods) begin
      halves(1'b1, 4);
      halves(1'b0, 4);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},  int'(VALID),    0);
    chk({tag, "_period"}, int'(PERIOD_H), 0);
    chk({tag, "_high"},   int'(HIGH_H),   0);
    chk({tag, "_ovf"},    int'(OVF),      0);
    chk({tag, "_miss"},   int'(MISS),     0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 CLRn = 1'b0; SIG = 1'b0; ACK = 1'b0;
    #1 check_zero("rst");
    repeat (2) @(posedge CLK);
    #2 CLRn = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (VALID === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  bit rand_done;

  initial begin
    int at, t0, vs;
    checks = 0; failures = 0; cyc = 0;

    // Divide-by-7 dual-edge, ACK always high.
    do_reset();
    ACK = 1'b1;
    fork
      div7(6);
      begin
        wait_valid(80, at);
        chk("a_valid_seen", int'(at >= 0), 1);
        chk("a_period", int'(PERIOD_H), 14);
        chk("a_high",   int'(HIGH_H),   7);
        chk("a_model_period", m_p, 14);
        t0 = at;
        wait_valid(20, at);
        chk("a_gap", at - t0, 7);
      end
    join

    // Posedge-only divide-by-4.
    do_reset();
    ACK = 1'b1;
    @(negedge CLK);
    fork
      div4(6);
      begin
        wait_valid(60, at);
        chk("b_valid_seen", int'(at >= 0), 1);
        chk("b_period", int'(PERIOD_H), 8);
        chk("b_high",   int'(HIGH_H),   4);
        chk("b_model_high", m_h, 4);
      end
    join

    // ACK held low over three periods, then one accept.
    do_reset();
    fork
      div7(7);
      begin
        wait_valid(80, at);
        repeat (21) @(negedge CLK);
        chk("c_valid", int'(VALID), 1);
        chk("c_period", int'(PERIOD_H), 14);
        chk("c_miss", int'(MISS), 1);
        #1 ACK = 1'b1;
        @(negedge CLK);
        chk("c_valid_ack", int'(VALID), 0);
        chk("c_miss_ack", int'(MISS), 0);
        ACK = 1'b0;
      end
    join

    // SIG stuck high, then resume divide-by-7.
    do_reset();
    ACK = 1'b1;
    halves(1'b0, 4);
    fork
      halves(1'b1, 80);
      begin
        vs = 0;
        repeat (39) begin
          @(negedge CLK);
          vs += int'(VALID);
        end
        chk("d_no_valid", vs, 0);
      end
    join
    chk("d_ovf", int'(OVF), 1);
    chk("d_model_ovf", int'(m_ovf), 1);
    fork
      div7(5);
      begin
        wait_valid(70, at);
        chk("d_valid_seen", int'(at >= 0), 1);
        chk("d_period", int'(PERIOD_H), 14);
        chk("d_ovf_clr", int'(OVF), 0);
      end
    join

    // ACK coincident with a publish while a miss is pending.
    do_reset();
    fork
      div7(6);
      begin
        wait_valid(80, at);
        repeat (13) @(negedge CLK);
        chk("e_miss_before", int'(MISS), 1);
        #1 ACK = 1'b1;
        @(negedge CLK);
        chk("e_valid", int'(VALID), 1);
        chk("e_miss", int'(MISS), 0);
        chk("e_period", int'(PERIOD_H), 14);
        chk("e_high", int'(HIGH_H), 7);
        @(negedge CLK);
        chk("e_valid_next", int'(VALID), 0);
        ACK = 1'b0;
      end
    join

    // Reset pulse mid-period.
    do_reset();
    ACK = 1'b1;
    fork
      div7(8);
      begin
        wait_valid(80, at);
        repeat (3) @(negedge CLK);
        #2 CLRn = 1'b0;
        #1 check_zero("f_rst");
        @(posedge CLK);
        #2 CLRn = 1'b1;
        vs = 0;
        repeat (8) begin
          @(negedge CLK);
          vs += int'(VALID);
        end
        chk("f_no_early_valid", vs, 0);
      end
    join

    // Randomized SIG, ACK and occasional reset pulses.
    do_reset();
    rand_done = 1'b0;
    fork
      begin
        bit v;
        int len;
        v = 1'b0;
        for (int seg = 0; seg < 250; seg++) begin
          len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(60, 80))
                                             : int'($urandom_range(1, 12));
          halves(v, len);
          v = !v;
          if ($urandom_range(0, 59) == 0) begin
            #1 CLRn = 1'b0;
            #1 CLRn = 1'b1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge CLK);
          #1 ACK = 1'($urandom_range(0, 1));
        end
      end
    join

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
